// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute over 3-5 cycles,
// stalls on mem_ready, handles illegal opcodes and counts retired instructions.
module multicycle_control #(
  parameter int unsigned ALUOP_W       = 3,
  parameter bit          USE_MEM_READY = 1'b1,
  parameter bit          TRAP_HALT     = 1'b1,
  parameter int unsigned CNT_W         = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               branch_ne,
  output logic               ir_write,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_source,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               illegal_op,
  output logic               instr_done,
  output logic [3:0]         state,
  output logic [CNT_W-1:0]   instr_count
);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_J    = 6'h02;

  typedef enum logic [3:0] {
    RESET_ST  = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    MEM_ADDR  = 4'd3,
    MEM_READ  = 4'd4,
    MEM_WB    = 4'd5,
    MEM_WRITE = 4'd6,
    R_EXEC    = 4'd7,
    R_WB      = 4'd8,
    BRANCH    = 4'd9,
    ADDI_EXEC = 4'd10,
    ADDI_WB   = 4'd11,
    JUMP      = 4'd12,
    TRAP      = 4'd13
  } state_t;

  state_t     stateQ, stateNext;
  logic [5:0] opQ;
  logic       armed;
  logic       memRdy;

  assign memRdy = USE_MEM_READY ? mem_ready : 1'b1;
  assign state  = stateQ;

  // armed delays the first FETCH to the second edge after reset release
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ      <= RESET_ST;
      opQ         <= 6'd0;
      armed       <= 1'b0;
      instr_count <= '0;
    end else begin
      stateQ <= stateNext;
      armed  <= 1'b1;
      if (stateQ == DECODE) opQ <= op;
      if (instr_done) instr_count <= instr_count + CNT_W'(1);
    end
  end

  always_comb begin
    stateNext     = stateQ;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    ir_write      = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_source     = 2'b00;
    alu_op        = '0;
    illegal_op    = 1'b0;
    instr_done    = 1'b0;
    unique case (stateQ)
      RESET_ST: if (armed) stateNext = FETCH;
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (memRdy) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          stateNext = DECODE;
        end
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (op)
          OP_R:          stateNext = R_EXEC;
          OP_LW, OP_SW:  stateNext = MEM_ADDR;
          OP_BEQ, OP_BNE: stateNext = BRANCH;
          OP_ADDI:       stateNext = ADDI_EXEC;
          OP_J:          stateNext = JUMP;
          default: begin
            if (TRAP_HALT) begin
              stateNext = TRAP;
            end else begin
              stateNext  = FETCH;
              illegal_op = 1'b1;
            end
          end
        endcase
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        stateNext = (opQ == OP_LW) ? MEM_READ : MEM_WRITE;
      end
      MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (memRdy) stateNext = MEM_WB;
      end
      MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        stateNext  = FETCH;
      end
      MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (memRdy) begin
          instr_done = 1'b1;
          stateNext  = FETCH;
        end
      end
      R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_W'(3'b001);
        stateNext = R_WB;
      end
      R_WB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        stateNext  = FETCH;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_W'(3'b010);
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        branch_ne     = (opQ == OP_BNE);
        instr_done    = 1'b1;
        stateNext     = FETCH;
      end
      ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        stateNext = ADDI_WB;
      end
      ADDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        stateNext  = FETCH;
      end
      JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
        stateNext  = FETCH;
      end
      TRAP: illegal_op = 1'b1;
      default: stateNext = RESET_ST;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: a per-instruction model expands each
// opcode and stall pattern into the expected per-cycle state/strobe trace.
module tb_multicycle_control;

  typedef struct packed {
    logic [3:0] st;
    logic pcW, pcWC, bNe, irW, iOrD, mRd, mWr, m2r, rDst, rW, aSa;
    logic [1:0] aSb, pSrc;
    logic [2:0] aOp;
    logic ill, done;
  } obs_t;

  typedef struct {
    bit          sel;
    obs_t        o;
    logic [31:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetA = 1'b0, resetB = 1'b0, mrA = 1'b0, mrB = 1'b0;
  logic [5:0] opA = 6'd0, opB = 6'd0;

  logic pcWA, pcWCA, bNeA, irWA, iOrDA, mRdA, mWrA, m2rA, rDstA, rWA, aSaA, illA, doneA;
  logic pcWB, pcWCB, bNeB, irWB, iOrDB, mRdB, mWrB, m2rB, rDstB, rWB, aSaB, illB, doneB;
  logic [1:0] aSbA, pSrcA, aSbB, pSrcB;
  logic [2:0] aOpA, aOpB;
  logic [3:0] stA, stB;
  logic [31:0] cntA;
  logic [3:0]  cntB;
  obs_t obsA, obsB;

  assign obsA = {stA, pcWA, pcWCA, bNeA, irWA, iOrDA, mRdA, mWrA, m2rA, rDstA, rWA, aSaA,
                 aSbA, pSrcA, aOpA, illA, doneA};
  assign obsB = {stB, pcWB, pcWCB, bNeB, irWB, iOrDB, mRdB, mWrB, m2rB, rDstB, rWB, aSaB,
                 aSbB, pSrcB, aOpB, illB, doneB};

  multicycle_control #(.ALUOP_W(3), .USE_MEM_READY(1'b1), .TRAP_HALT(1'b1), .CNT_W(32)) dutA (
    .clk(clk), .reset(resetA), .op(opA), .mem_ready(mrA),
    .pc_write(pcWA), .pc_write_cond(pcWCA), .branch_ne(bNeA), .ir_write(irWA),
    .i_or_d(iOrDA), .mem_read(mRdA), .mem_write(mWrA), .mem_to_reg(m2rA),
    .reg_dst(rDstA), .reg_write(rWA), .alu_src_a(aSaA), .alu_src_b(aSbA),
    .pc_source(pSrcA), .alu_op(aOpA), .illegal_op(illA), .instr_done(doneA),
    .state(stA), .instr_count(cntA));

  multicycle_control #(.ALUOP_W(3), .USE_MEM_READY(1'b1), .TRAP_HALT(1'b0), .CNT_W(4)) dutB (
    .clk(clk), .reset(resetB), .op(opB), .mem_ready(mrB),
    .pc_write(pcWB), .pc_write_cond(pcWCB), .branch_ne(bNeB), .ir_write(irWB),
    .i_or_d(iOrDB), .mem_read(mRdB), .mem_write(mWrB), .mem_to_reg(m2rB),
    .reg_dst(rDstB), .reg_write(rWB), .alu_src_a(aSaB), .alu_src_b(aSbB),
    .pc_source(pSrcB), .alu_op(aOpB), .illegal_op(illB), .instr_done(doneB),
    .state(stB), .instr_count(cntB));

  exp_t sbq[$];
  int   nCmp = 0, nErr = 0;
  int   modelCnt[2] = '{0, 0};
  bit   sel = 1'b0;
  logic [5:0] legalOps[7] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h02};

  function automatic bit isLegal(input logic [5:0] o);
    return o inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h02};
  endfunction

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [5:0] r6();
    return 6'($urandom_range(0, 63));
  endfunction

  // Strobe table: what the datapath should see in each named step.
  function automatic obs_t expOut(input logic [3:0] st, input bit mr, input logic [5:0] iop,
                                  input bit halt);
    obs_t o;
    o = '0;
    o.st = st;
    case (st)
      4'd1:  begin o.mRd = 1; o.aSb = 2'b01; o.irW = mr; o.pcW = mr; end
      4'd2:  begin o.aSb = 2'b11; o.ill = !halt && !isLegal(iop); end
      4'd3:  begin o.aSa = 1; o.aSb = 2'b10; end
      4'd4:  begin o.mRd = 1; o.iOrD = 1; end
      4'd5:  begin o.m2r = 1; o.rW = 1; o.done = 1; end
      4'd6:  begin o.mWr = 1; o.iOrD = 1; o.done = mr; end
      4'd7:  begin o.aSa = 1; o.aOp = 3'b001; end
      4'd8:  begin o.rDst = 1; o.rW = 1; o.done = 1; end
      4'd9:  begin o.aSa = 1; o.aOp = 3'b010; o.pcWC = 1; o.pSrc = 2'b01;
                   o.bNe = (iop == 6'h05); o.done = 1; end
      4'd10: begin o.aSa = 1; o.aSb = 2'b10; end
      4'd11: begin o.rW = 1; o.done = 1; end
      4'd12: begin o.pcW = 1; o.pSrc = 2'b10; o.done = 1; end
      4'd13: o.ill = 1;
      default: ;
    endcase
    return o;
  endfunction

  // One clock of stimulus plus the expected observation for that cycle.
  task automatic cyc(input logic [3:0] st, input bit mr, input logic [5:0] dop,
                     input logic [5:0] iop, input bit rst);
    exp_t e;
    @(posedge clk);
    #1;
    if (sel) begin mrB = mr; opB = dop; resetB = rst; end
    else     begin mrA = mr; opA = dop; resetA = rst; end
    if (rst) begin
      modelCnt[sel] = 0;
      #1;
      nCmp++;
      if ((sel ? obsB : obsA) !== obs_t'(0) || (sel ? 32'(cntB) : cntA) !== 32'd0) begin
        nErr++;
        $display("FAIL async-reset t=%0t dut=%0d got obs=%h cnt=%0d required obs=0 cnt=0",
                 $time, sel, sel ? obsB : obsA, sel ? 32'(cntB) : cntA);
      end
    end
    e.sel = sel;
    e.o   = expOut(st, mr, iop, !sel);
    e.cnt = sel ? 32'(modelCnt[1] % 16) : 32'(modelCnt[0]);
    sbq.push_back(e);
    if (e.o.done) modelCnt[sel]++;
  endtask

  task automatic resetSeq();
    cyc(4'd0, rb(), r6(), 6'd0, 1'b1);
    cyc(4'd0, rb(), r6(), 6'd0, 1'b0);
    cyc(4'd0, rb(), r6(), 6'd0, 1'b0);
  endtask

  // Expand one instruction into its cycle trace; junk op outside DECODE.
  task automatic runInstr(input logic [5:0] iop, input int fs, input int ms);
    for (int i = 0; i < fs; i++) cyc(4'd1, 1'b0, r6(), iop, 1'b0);
    cyc(4'd1, 1'b1, r6(), iop, 1'b0);
    cyc(4'd2, rb(), iop, iop, 1'b0);
    case (iop)
      6'h00: begin cyc(4'd7, rb(), r6(), iop, 1'b0); cyc(4'd8, rb(), r6(), iop, 1'b0); end
      6'h23: begin
        cyc(4'd3, rb(), r6(), iop, 1'b0);
        for (int i = 0; i < ms; i++) cyc(4'd4, 1'b0, r6(), iop, 1'b0);
        cyc(4'd4, 1'b1, r6(), iop, 1'b0);
        cyc(4'd5, rb(), r6(), iop, 1'b0);
      end
      6'h2B: begin
        cyc(4'd3, rb(), r6(), iop, 1'b0);
        for (int i = 0; i < ms; i++) cyc(4'd6, 1'b0, r6(), iop, 1'b0);
        cyc(4'd6, 1'b1, r6(), iop, 1'b0);
      end
      6'h04, 6'h05: cyc(4'd9, rb(), r6(), iop, 1'b0);
      6'h08: begin cyc(4'd10, rb(), r6(), iop, 1'b0); cyc(4'd11, rb(), r6(), iop, 1'b0); end
      6'h02: cyc(4'd12, rb(), r6(), iop, 1'b0);
      default: if (!sel) for (int i = 0; i < 4; i++) cyc(4'd13, rb(), r6(), iop, 1'b0);
    endcase
  endtask

  function automatic logic [5:0] randIllegal();
    logic [5:0] x;
    x = r6();
    while (isLegal(x)) x = r6();
    return x;
  endfunction

  // Monitor: pop and compare one expected observation per cycle.
  initial begin
    exp_t e;
    obs_t got;
    logic [31:0] gotCnt;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        got    = e.sel ? obsB : obsA;
        gotCnt = e.sel ? 32'(cntB) : cntA;
        nCmp++;
        if (got !== e.o || gotCnt !== e.cnt) begin
          nErr++;
          $display("FAIL cycle t=%0t dut=%0d got state=%0d obs=%h cnt=%0d required state=%0d obs=%h cnt=%0d",
                   $time, e.sel, got.st, got, gotCnt, e.o.st, e.o, e.cnt);
        end
      end
    end
  end

  initial begin
    #2 resetB = 1'b1;
    sel = 1'b0;
    resetSeq();
    runInstr(6'h00, 0, 0);
    runInstr(6'h08, 0, 0);
    runInstr(6'h02, 0, 0);
    runInstr(6'h23, 2, 3);
    runInstr(6'h2B, 0, 1);
    runInstr(6'h04, 0, 0);
    runInstr(6'h05, 1, 0);
    for (int n = 0; n < 30; n++)
      runInstr(legalOps[$urandom_range(0, 6)], $urandom_range(0, 2), $urandom_range(0, 2));
    // reset in the middle of a MEM_READ stall
    cyc(4'd1, 1'b1, r6(), 6'h23, 1'b0);
    cyc(4'd2, rb(), 6'h23, 6'h23, 1'b0);
    cyc(4'd3, rb(), r6(), 6'h23, 1'b0);
    cyc(4'd4, 1'b0, r6(), 6'h23, 1'b0);
    cyc(4'd4, 1'b0, r6(), 6'h23, 1'b0);
    resetSeq();
    runInstr(6'h00, 0, 0);
    runInstr(6'h3F, 0, 0);
    resetSeq();
    runInstr(6'h2B, 1, 2);

    @(posedge clk);
    #1 resetA = 1'b1;
    sel = 1'b1;
    resetSeq();
    runInstr(6'h3F, 0, 0);
    for (int n = 0; n < 22; n++) begin
      if (n % 7 == 3) runInstr(randIllegal(), $urandom_range(0, 1), 0);
      else runInstr(legalOps[$urandom_range(0, 6)], $urandom_range(0, 2), $urandom_range(0, 2));
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    nCmp++;
    if (sbq.size() != 0) begin
      nErr++;
      $display("FAIL scoreboard-drain got %0d pending required 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
